spi_master_tx: RTL and testbench

- SPI mode-0 master (CPOL=0, CPHA=0) that drives the synth's slave-side SPI input pins: SCLK, MOSI and SS.
- Used by the control front-end and by the integration bench to write frequency/control bytes into the synth.
- Full duplex: the byte shifted in on MISO is returned with a one-cycle valid strobe.
- Runs entirely on the system clock and generates SCLK by division.

---
 rtl/spi_master_tx.sv | 160 ++++++++++++++++
 tb/tb_spi_master_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: one DATA_W frame per accept, SS-to-SS-high in CLK_DIV*(2*DATA_W+2) cycles after accept.
// Backpressure: o_ready stays low from accept until the inter-frame gap ends; requests meanwhile are dropped.
module spi_master_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_spi_clk,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso,
  output logic              o_spi_ss
);

  localparam int              BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]      DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
      $error("spi_master_tx: CLK_DIV must be within 2..255");
    end
    if (DATA_W < 2) begin : g_bad_width
      $error("spi_master_tx: DATA_W must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                rx_valid_q, rx_valid_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ss_q, ss_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;

    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          state_d = SETUP;
          cnt_d   = DIV_M1;
          bit_d   = '0;
          tx_d    = i_data;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          mosi_d  = i_data[DATA_W-1];
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = SHIFT;
          cnt_d   = DIV_M1;
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], i_spi_miso};
        end
      end
      SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d = DIV_M1;
          if (sclk_q) begin
            // Falling edge: present the next bit; zero fill keeps MOSI low once the word is spent.
            sclk_d = 1'b0;
            tx_d   = tx_q << 1;
            mosi_d = tx_q[DATA_W-2];
          end else if (bit_q == LAST_BIT) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            sclk_d  = 1'b1;
            bit_d   = bit_q + 1'b1;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], i_spi_miso};
          end
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d    = GAP;
          cnt_d      = DIV_M1;
          ss_d       = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_ss   = ss_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: scoreboard of expected frames checked by a monitor, plus a slave model per instance.
module tb_spi_master_tx;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, valid, valid2;
  logic [7:0] data, data2;
  logic       ready, busy, rx_valid, sclk, mosi, ss, miso;
  logic [7:0] rx_data;
  logic       ready2, busy2, rx_valid2, sclk2, mosi2, ss2, miso2;
  logic [7:0] rx_data2;
  int         mode;

  assign miso  = (mode == 0) ? mosi : (mode == 1);
  assign miso2 = mosi2;

  spi_master_tx #(.DATA_W(W), .CLK_DIV(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_busy(busy), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_spi_clk(sclk), .o_spi_mosi(mosi), .i_spi_miso(miso), .o_spi_ss(ss));

  spi_master_tx #(.DATA_W(W), .CLK_DIV(D2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .i_data(data2),
    .o_ready(ready2), .o_busy(busy2), .o_rx_data(rx_data2), .o_rx_valid(rx_valid2),
    .o_spi_clk(sclk2), .o_spi_mosi(mosi2), .i_spi_miso(miso2), .o_spi_ss(ss2));

  // Minimal mode-0 slaves: shift MOSI on SCLK rise, publish the byte when SS rises.
  logic [7:0] sl_sr = 8'h00, sl_byte = 8'h00, sl2_sr = 8'h00, sl2_byte = 8'h00;
  always @(posedge sclk)  if (!ss)  sl_sr  <= {sl_sr[6:0], mosi};
  always @(posedge ss)    sl_byte  <= sl_sr;
  always @(posedge sclk2) if (!ss2) sl2_sr <= {sl2_sr[6:0], mosi2};
  always @(posedge ss2)   sl2_byte <= sl2_sr;

  int total = 0, bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [7:0] tx; logic [7:0] rx; } frm_t;
  frm_t exp_q[$];
  int   pushed = 0;

  function automatic logic [7:0] model_rx(input logic [7:0] tx, input int m);
    if (m == 0) return tx;
    if (m == 1) return 8'hFF;
    return 8'h00;
  endfunction

  // Monitor: one sample per negedge; frame timing is measured from the accept sample.
  int   cyc = 0, t0 = 0, rises = 0, frames = 0, ss_hi_run = 1000;
  int   bad_sclk = 0, bad_busy = 0, bad_mosi = 0;
  bit   active = 0;
  frm_t cur;
  logic [7:0] mword = 8'h00;
  logic p_sclk = 1'b0, p_ready = 1'b1, p_ss = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      active    = 0;
      p_sclk    = 1'b0;
      p_ready   = 1'b1;
      p_ss      = 1'b1;
      ss_hi_run = 1000;
    end else begin
      if (ss && sclk) bad_sclk++;
      if (busy === ready) bad_busy++;
      if (active && cur.tx == 8'h00 && mosi) bad_mosi++;
      if (active && sclk && !p_sclk) begin
        rises++;
        mword = {mword[6:0], mosi};
      end
      if (rx_valid) begin
        if (!active) check("unexpected_rx_valid", 1, 0);
        else begin
          check("rx_data", rx_data, cur.rx);
          check("rx_valid_cycle", cyc - t0, 1 + D * (2 * W + 2));
          check("sclk_rises", rises, W);
          check("mosi_bits", mword, cur.tx);
          frames++;
        end
      end
      if (ready && !p_ready && active) begin
        check("ready_cycle", cyc - t0, 1 + D * (2 * W + 3));
        active = 0;
      end
      if (!ss && p_ss) check("ss_gap_ge_div", ss_hi_run >= D, 1);
      ss_hi_run = ss ? ss_hi_run + 1 : 0;
      if (valid && ready) begin
        if (exp_q.size() == 0) check("unexpected_accept", 0, 1);
        else begin
          cur    = exp_q.pop_front();
          active = 1;
          t0     = cyc;
          rises  = 0;
          mword  = 8'h00;
        end
      end
      p_sclk  = sclk;
      p_ready = ready;
      p_ss    = ss;
    end
  end

  task automatic send(input logic [7:0] d, input bit keep, output int waits);
    logic acc;
    exp_q.push_back('{tx: d, rx: model_rx(d, mode)});
    pushed++;
    valid = 1'b1;
    data  = d;
    waits = 0;
    do begin
      acc = ready;
      @(posedge clk); #2;
      waits++;
    end while (!acc && waits < 300);
    if (!acc) check("accept_timeout", 0, 1);
    if (!keep) valid = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready && !active) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic send2(input logic [7:0] d);
    int n = 0;
    logic acc;
    valid2 = 1'b1;
    data2  = d;
    do begin
      acc = ready2;
      @(posedge clk); #2;
      n++;
    end while (!acc && n < 300);
    valid2 = 1'b0;
    data2  = 8'($urandom);
    n = 0;
    while (!rx_valid2 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check("div2_rx_valid_cycle", n, D2 * (2 * W + 2));
    check("div2_slave_byte", sl2_byte, d);
    check("div2_loopback_rx", rx_data2, d);
    n = 0;
    while (!ready2 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check("div2_ready_cycles", n, D2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  w;
    bit  keep, prev_keep;
    logic [7:0] d;
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; valid2 = 1'b0; data2 = 8'h00; mode = 0;
    #23;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ss", ss, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    mode = 0; send(8'hA5, 0, w); wait_idle();
    check("slave_byte_a5", sl_byte, 8'hA5);
    mode = 1; send(8'h00, 0, w); wait_idle();
    check("tie1_rx", rx_data, 8'hFF);
    mode = 2; send(8'h00, 0, w); wait_idle();
    check("tie0_rx", rx_data, 8'h00);

    mode = 0;
    send(8'h3C, 1, w);
    send(8'hC3, 0, w);
    check("b2b_accept_wait", w, D * (2 * W + 3) + 1);
    wait_idle();

    send(8'hA5, 0, w);
    repeat (9) @(posedge clk);
    #2;
    valid = 1'b1; data = 8'h77;
    @(posedge clk); #2;
    valid = 1'b0;
    wait_idle();
    repeat (100) @(posedge clk);
    #2;
    check("ignored_pulse_rx", rx_data, 8'hA5);

    send(8'hE7, 0, w);
    repeat (29) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ss", ss, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rx_data", rx_data, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    send(8'h5A, 0, w); wait_idle();
    check("post_rst_rx", rx_data, 8'h5A);

    send(8'h3C, 0, w); wait_idle();
    check("slave_byte_3c", sl_byte, 8'h3C);

    prev_keep = 0;
    for (int i = 0; i < 20; i++) begin
      if (!prev_keep) mode = int'($urandom_range(0, 2));
      keep = ($urandom_range(0, 3) == 0) && (i < 19);
      d    = 8'($urandom);
      send(d, keep, w);
      if (!keep) begin
        wait_idle();
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #2;
      end
      prev_keep = keep;
    end
    wait_idle();

    send2(8'h3C);
    send2(8'hA5);
    for (int i = 0; i < 3; i++) send2(8'($urandom));

    repeat (10) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    check("frames_completed", frames, pushed - 1);
    check("sclk_while_ss_high", bad_sclk, 0);
    check("busy_vs_ready", bad_busy, 0);
    check("mosi_low_zero_frames", bad_mosi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
